reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: width of the shared register data path.
REQ-002 Parameter N_REQ, default 3: number of write requesters.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  N_REQ  per-requester write request, level, held until ACK.
REQ-006 REQ_WD  input  N_REQ*DATA_W  per-requester write data; slice i = bits [i*DATA_W +: DATA_W].
REQ-007 GNT  output  N_REQ  one-hot grant, high in WRITE and ACK states for the winner.
REQ-008 ACK  output  N_REQ  one-hot, one-cycle pulse confirming the write is committed.
REQ-009 WD  output  DATA_W  registered data to the shared register's WD port.
REQ-010 WF  output  1  registered write flag to the shared register's WF port.
REQ-011 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, WRITE, ACK.
REQ-013 In IDLE with REQ == 0, the FSM SHALL stay in IDLE with WF=0, GNT=0, ACK=0.
REQ-014 In IDLE with any REQ bit set, the arbiter SHALL select one winner round-robin, starting the search at pointer PTR and wrapping from N_REQ-1 to 0.
REQ-015 On that edge the arbiter SHALL register WD = REQ_WD slice of the winner, WF=1, and GNT = winner one-hot, and SHALL enter WRITE.
REQ-016 In WRITE, WF SHALL be 1 for exactly this one cycle, so the shared register captures WD at the edge leaving WRITE; the next state SHALL be ACK.
REQ-017 In ACK, WF SHALL be 0, WD SHALL hold its value, and ACK[winner] SHALL be 1 for exactly one cycle.
REQ-018 Leaving ACK, PTR SHALL become (winner+1) mod N_REQ, GNT SHALL clear, and the next state SHALL be IDLE.
REQ-019 Latency: REQ first sampled high at edge k -> WF high during cycle k..k+1 -> register updated at edge k+1 -> ACK high during cycle k+1..k+2; peak throughput is one write per 3 cycles.
REQ-020 If the winner drops REQ during WRITE or ACK, the write SHALL still complete and ACK SHALL still pulse, because data was captured at grant time.
REQ-021 Changes on REQ_WD after the grant SHALL NOT affect WD.
REQ-022 A REQ bit still high in IDLE after its ACK SHALL be treated as a new request, with priority determined by the advanced PTR.
REQ-023 GNT and ACK SHALL never have more than one bit set.

Reset
REQ-024 When RST_N is low, the arbiter SHALL immediately set state=IDLE, PTR=0, WD=0, WF=0, GNT=0, ACK=0, BUSY=0, independent of CLK.
REQ-025 If reset asserts during WRITE, WF SHALL drop asynchronously, no ACK SHALL be issued, and the aborted requester SHALL re-request.
REQ-026 After RST_N deasserts, the first arbitration SHALL occur at the first rising CLK edge at which REQ is nonzero.

Structure
REQ-027 The state encoding (IDLE/WRITE/ACK) and the DATA_W/N_REQ defaults SHALL live in the shared package reg_arb_pkg.
REQ-028 The round-robin winner selection SHALL be a combinational sub-module, rr_pick (inputs: REQ, PTR; outputs: one-hot winner, winner index).
REQ-029 The FSM, PTR, and the output registers SHALL be in reg_write_arbiter.
REQ-030 The arbiter SHALL drive a Reg16 instance directly, with WD->WD and WF->WF.

Verification
REQ-031 Reset then single request: REQ=3'b001, slice0=16'h1234 -> WF=1 for one cycle, Reg16 RD=16'h1234, ACK=3'b001 one cycle later, PTR=1.
REQ-032 Contention: REQ=3'b111 held, data 16'h1111/16'h2222/16'h3333 -> grants in order 0,1,2,0; RD follows 1111, 2222, 3333 at 3-cycle spacing.
REQ-033 Wrap: PTR=2, REQ=3'b101 -> requester 2 wins first, then requester 0; no requester is starved.
REQ-034 Data change after grant: REQ_WD slice changed 16'h4321->16'hFFFF during WRITE -> RD=16'h4321.
REQ-035 Withdraw: REQ dropped in WRITE -> ACK still pulses, RD updated, FSM returns to IDLE.
REQ-036 Async reset in WRITE -> WF=0 and BUSY=0 before the next edge, RD unchanged (16'h0000 from prior reset), no ACK.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: defaults, FSM states
// and a helper for the pointer width.
package reg_arb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int N_REQ_DEF  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } arb_state_e;

   // Index width that stays legal even for a single requester.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first set REQ bit at or after PTR, wrapping.
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PTR_W = ptr_width(N_REQ)
) (
   input  logic [N_REQ-1:0] REQ,
   input  logic [PTR_W-1:0] PTR,
   output logic [N_REQ-1:0] WIN_OH,
   output logic [PTR_W-1:0] WIN_IDX
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      WIN_OH  = '0;
      WIN_IDX = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned off = 0; off < int'(N_REQ); off++) begin
         idx = PTR_W'((int'(PTR) + int'(off)) % N_REQ);
         if (!found && REQ[idx]) begin
            found   = 1'b1;
            WIN_IDX = idx;
            WIN_OH  = N_REQ'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter feeding one shared register: grant, one-cycle write
// strobe, then a one-cycle acknowledge to the winner.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_REQ  = N_REQ_DEF
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [N_REQ-1:0]        REQ,
   input  logic [N_REQ*DATA_W-1:0] REQ_WD,
   output logic [N_REQ-1:0]        GNT,
   output logic [N_REQ-1:0]        ACK,
   output logic [DATA_W-1:0]       WD,
   output logic                    WF,
   output logic                    BUSY
);

   localparam int PTR_W = ptr_width(N_REQ);

   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic              wf_q, wf_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  ack_q, ack_d;

   logic [N_REQ-1:0]  win_oh;
   logic [PTR_W-1:0]  win_idx;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .REQ     (REQ),
      .PTR     (ptr_q),
      .WIN_OH  (win_oh),
      .WIN_IDX (win_idx)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         wd_q    <= '0;
         wf_q    <= 1'b0;
         gnt_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         wd_q    <= wd_d;
         wf_q    <= wf_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      wd_d    = wd_q;
      wf_d    = 1'b0;
      gnt_d   = gnt_q;
      ack_d   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (|REQ) begin
               // Data is captured here so later REQ_WD changes cannot leak in.
               for (int unsigned i = 0; i < int'(N_REQ); i++) begin
                  if (win_idx == PTR_W'(i)) wd_d = REQ_WD[i*DATA_W +: DATA_W];
               end
               wf_d    = 1'b1;
               gnt_d   = win_oh;
               idx_d   = win_idx;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            ack_d   = gnt_q;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            gnt_d   = '0;
            ptr_d   = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign GNT  = gnt_q;
   assign ACK  = ack_q;
   assign WD   = wd_q;
   assign WF   = wf_q;
   assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural Reg16 on WD/WF.
module tb_reg_write_arbiter;

   localparam int DATA_W = 16;
   localparam int N_REQ  = 3;

   logic                    clk;
   logic                    rst_n;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_wd;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic [DATA_W-1:0]       wd;
   logic                    wf;
   logic                    busy;
   logic [DATA_W-1:0]       rd;

   int n_cmp;
   int n_bad;

   reg_write_arbiter #(
      .DATA_W (DATA_W),
      .N_REQ  (N_REQ)
   ) dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .REQ    (req),
      .REQ_WD (req_wd),
      .GNT    (gnt),
      .ACK    (ack),
      .WD     (wd),
      .WF     (wf),
      .BUSY   (busy)
   );

   // Shared Reg16: captures WD on an edge where WF is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rd <= '0;
      else if (wf) rd <= wd;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Grant and acknowledge must never be more than one-hot.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
         chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
      end
   end

   initial begin
      logic [N_REQ-1:0] exp_oh;
      logic [DATA_W-1:0] exp_d;
      int order [4];
      order = '{0, 1, 2, 0};

      n_cmp  = 0;
      n_bad  = 0;
      rst_n  = 1'b0;
      req    = '0;
      req_wd = '0;
      #3;
      chk("rst_wf", 32'(wf), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wd", 32'(wd), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wf", 32'(wf), 32'd0);

      // Single request from requester 0.
      req = 3'b001;
      req_wd[0 +: 16] = 16'h1234;
      tick();
      chk("single_wf", 32'(wf), 32'd1);
      chk("single_gnt", 32'(gnt), 32'h1);
      chk("single_wd", 32'(wd), 32'h1234);
      chk("single_ack_early", 32'(ack), 32'd0);
      chk("single_busy", 32'(busy), 32'd1);
      tick();
      chk("single_wf_drop", 32'(wf), 32'd0);
      chk("single_ack", 32'(ack), 32'h1);
      chk("single_rd", 32'(rd), 32'h1234);
      req = 3'b000;
      tick();
      chk("single_ack_end", 32'(ack), 32'd0);
      chk("single_gnt_end", 32'(gnt), 32'd0);
      chk("single_idle", 32'(busy), 32'd0);

      // PTR should now be 1: requester 1 beats requester 0.
      req = 3'b011;
      req_wd[0 +: 16]  = 16'h5555;
      req_wd[16 +: 16] = 16'hABCD;
      tick();
      chk("ptr1_gnt", 32'(gnt), 32'h2);
      chk("ptr1_wd", 32'(wd), 32'hABCD);
      tick();
      chk("ptr1_ack", 32'(ack), 32'h2);
      req = 3'b000;
      tick();

      // Reset while idle brings PTR back to 0.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("midrst_rd", 32'(rd), 32'd0);

      // Contention with all requests held: 0,1,2,0.
      req = 3'b111;
      req_wd = {16'h3333, 16'h2222, 16'h1111};
      for (int k = 0; k < 4; k++) begin
         exp_oh = 3'(1 << order[k]);
         exp_d  = 16'h1111 * 16'(order[k] + 1);
         tick();
         chk($sformatf("cont%0d_gnt", k), 32'(gnt), 32'(exp_oh));
         chk($sformatf("cont%0d_wf", k), 32'(wf), 32'd1);
         tick();
         chk($sformatf("cont%0d_ack", k), 32'(ack), 32'(exp_oh));
         chk($sformatf("cont%0d_rd", k), 32'(rd), 32'(exp_d));
         tick();
         chk($sformatf("cont%0d_idle", k), 32'(busy), 32'd0);
      end
      req = 3'b000;

      // PTR is 1; serve requester 1 so PTR becomes 2, then test wrap.
      req = 3'b010;
      req_wd[16 +: 16] = 16'h0022;
      tick();
      chk("pre_wrap_gnt", 32'(gnt), 32'h2);
      tick();
      tick();
      req = 3'b101;
      req_wd[0 +: 16]  = 16'hA000;
      req_wd[32 +: 16] = 16'hC002;
      tick();
      chk("wrap1_gnt", 32'(gnt), 32'h4);
      tick();
      chk("wrap1_rd", 32'(rd), 32'hC002);
      tick();
      tick();
      chk("wrap2_gnt", 32'(gnt), 32'h1);
      tick();
      chk("wrap2_rd", 32'(rd), 32'hA000);
      req = 3'b000;
      tick();

      // Data change after grant is ignored (PTR is 1, only requester 0 asks).
      req = 3'b001;
      req_wd[0 +: 16] = 16'h4321;
      tick();
      chk("dchg_wd", 32'(wd), 32'h4321);
      req_wd[0 +: 16] = 16'hFFFF;
      tick();
      chk("dchg_rd", 32'(rd), 32'h4321);
      chk("dchg_wd_hold", 32'(wd), 32'h4321);
      chk("dchg_ack", 32'(ack), 32'h1);
      req = 3'b000;
      tick();

      // Withdraw during WRITE still completes.
      req = 3'b010;
      req_wd[16 +: 16] = 16'h0BEE;
      tick();
      chk("wdraw_gnt", 32'(gnt), 32'h2);
      req = 3'b000;
      tick();
      chk("wdraw_ack", 32'(ack), 32'h2);
      chk("wdraw_rd", 32'(rd), 32'h0BEE);
      tick();
      chk("wdraw_idle", 32'(busy), 32'd0);
      chk("wdraw_gnt_clr", 32'(gnt), 32'd0);

      // Async reset during WRITE aborts the write.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      req = 3'b100;
      req_wd[32 +: 16] = 16'h7777;
      tick();
      chk("abort_wf_pre", 32'(wf), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_wf", 32'(wf), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_gnt", 32'(gnt), 32'd0);
      tick();
      chk("abort_ack", 32'(ack), 32'd0);
      chk("abort_rd", 32'(rd), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rereq_gnt", 32'(gnt), 32'h4);
      chk("rereq_wd", 32'(wd), 32'h7777);
      tick();
      chk("rereq_ack", 32'(ack), 32'h4);
      chk("rereq_rd", 32'(rd), 32'h7777);
      req = 3'b000;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
